// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt entry/return sequencer.
package interrupt_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DRAIN,
        S_PUSH_PCH,
        S_PUSH_PCL,
        S_PUSH_CCR,
        S_VECTOR,
        S_POP_CCR,
        S_POP_PCL,
        S_POP_PCH,
        S_RESUME
    } state_t;

    localparam logic [1:0] SLOT_PCH = 2'd0;
    localparam logic [1:0] SLOT_PCL = 2'd1;
    localparam logic [1:0] SLOT_CCR = 2'd2;

    localparam logic [31:0] DEFAULT_INT_VECTOR = 32'h0000_0020;

endpackage

// File: rtl/int_edge_latch.sv
// One-deep rising-edge latch for the external interrupt pin.
module int_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic int_req,
    input  logic clear,
    output logic rise,
    output logic pending
);

    logic int_prev;

    assign rise = int_req & ~int_prev;

    // A fresh edge wins over a same-cycle clear so it is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_prev <= 1'b0;
            pending  <= 1'b0;
        end else begin
            int_prev <= int_req;
            if (rise)
                pending <= 1'b1;
            else if (clear)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry / RTI sequencer: drains fetch, pushes or pops the
// three-word frame through the memory stage, then redirects PC and CCR.
module interrupt_sequencer
    import interrupt_pkg::*;
#(
    parameter logic [31:0] INT_VECTOR   = DEFAULT_INT_VECTOR,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        int_req,
    input  logic        rti_req,
    input  logic [31:0] pc_in,
    input  logic [2:0]  ccr_in,
    input  logic [31:0] sp_in,
    input  logic [15:0] mem_rdata,
    output logic        fetch_stall,
    output logic        push,
    output logic        pop,
    output logic [1:0]  counter_val,
    output logic [31:0] stack_addr,
    output logic [15:0] stack_wdata,
    output logic [31:0] sp_out,
    output logic        sp_we,
    output logic        pc_load,
    output logic [31:0] pc_load_addr,
    output logic        ccr_load,
    output logic [2:0]  ccr_out,
    output logic        int_active
);

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    state_t      state;
    logic        is_rti;
    logic [3:0]  drain_cnt;
    logic [31:0] pc_sv;
    logic [2:0]  ccr_sv;
    logic [31:0] sp_r;
    logic [31:0] sp_dec;
    logic [31:0] sp_inc;
    logic        int_rise;
    logic        int_pending;
    logic        drain_done;
    logic        pend_clear;

    assign sp_dec     = sp_r - 32'd1;
    assign sp_inc     = sp_r + 32'd1;
    assign drain_done = (state == S_DRAIN) && (drain_cnt == 4'd0);
    assign pend_clear = drain_done && !is_rti;

    int_edge_latch u_edge (
        .clk     (clk),
        .rst     (rst),
        .int_req (int_req),
        .clear   (pend_clear),
        .rise    (int_rise),
        .pending (int_pending)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            is_rti    <= 1'b0;
            drain_cnt <= 4'd0;
            pc_sv     <= 32'd0;
            ccr_sv    <= 3'd0;
            sp_r      <= 32'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (rti_req || int_pending || int_rise) begin
                        is_rti    <= rti_req;
                        drain_cnt <= DRAIN_INIT;
                        state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == 4'd0) begin
                        pc_sv  <= pc_in;
                        ccr_sv <= ccr_in;
                        sp_r   <= sp_in;
                        state  <= is_rti ? S_POP_CCR : S_PUSH_PCH;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                S_PUSH_PCH: begin
                    sp_r  <= sp_dec;
                    state <= S_PUSH_PCL;
                end
                S_PUSH_PCL: begin
                    sp_r  <= sp_dec;
                    state <= S_PUSH_CCR;
                end
                S_PUSH_CCR: begin
                    sp_r  <= sp_dec;
                    state <= S_VECTOR;
                end
                S_VECTOR: state <= S_IDLE;
                S_POP_CCR: begin
                    sp_r  <= sp_inc;
                    state <= S_POP_PCL;
                end
                // Read data trails each pop by one cycle.
                S_POP_PCL: begin
                    sp_r   <= sp_inc;
                    ccr_sv <= mem_rdata[2:0];
                    state  <= S_POP_PCH;
                end
                S_POP_PCH: begin
                    sp_r        <= sp_inc;
                    pc_sv[15:0] <= mem_rdata;
                    state       <= S_RESUME;
                end
                S_RESUME: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        push         = 1'b0;
        pop          = 1'b0;
        counter_val  = SLOT_PCH;
        stack_addr   = 32'd0;
        stack_wdata  = 16'd0;
        sp_out       = 32'd0;
        sp_we        = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = 32'd0;
        ccr_load     = 1'b0;
        ccr_out      = 3'd0;
        int_active   = 1'b0;
        fetch_stall  = (state != S_IDLE);
        unique case (state)
            S_PUSH_PCH, S_PUSH_PCL, S_PUSH_CCR: begin
                push       = 1'b1;
                stack_addr = sp_r;
                sp_out     = sp_dec;
                sp_we      = 1'b1;
                int_active = 1'b1;
                if (state == S_PUSH_PCH) begin
                    counter_val = SLOT_PCH;
                    stack_wdata = pc_sv[31:16];
                end else if (state == S_PUSH_PCL) begin
                    counter_val = SLOT_PCL;
                    stack_wdata = pc_sv[15:0];
                end else begin
                    counter_val = SLOT_CCR;
                    stack_wdata = {13'd0, ccr_sv};
                end
            end
            S_VECTOR: begin
                pc_load      = 1'b1;
                pc_load_addr = INT_VECTOR;
                ccr_load     = 1'b1;
                int_active   = 1'b1;
            end
            S_POP_CCR, S_POP_PCL, S_POP_PCH: begin
                pop        = 1'b1;
                stack_addr = sp_inc;
                sp_out     = sp_inc;
                sp_we      = 1'b1;
                if (state == S_POP_CCR)
                    counter_val = SLOT_CCR;
                else if (state == S_POP_PCL)
                    counter_val = SLOT_PCL;
                else
                    counter_val = SLOT_PCH;
            end
            S_RESUME: begin
                pc_load      = 1'b1;
                pc_load_addr = {mem_rdata, pc_sv[15:0]};
                ccr_load     = 1'b1;
                ccr_out      = ccr_sv;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: directed entry, RTI,
// simultaneous, merge, reset-abort and SP-wrap scenarios.
module tb_interrupt_sequencer;

    localparam logic [31:0] VEC = 32'h0000_0020;

    logic        clk;
    logic        rst;
    logic        int_req;
    logic        rti_req;
    logic [31:0] pc_in;
    logic [2:0]  ccr_in;
    logic [31:0] sp_in;
    logic [15:0] mem_rdata;
    logic        fetch_stall;
    logic        push;
    logic        pop;
    logic [1:0]  counter_val;
    logic [31:0] stack_addr;
    logic [15:0] stack_wdata;
    logic [31:0] sp_out;
    logic        sp_we;
    logic        pc_load;
    logic [31:0] pc_load_addr;
    logic        ccr_load;
    logic [2:0]  ccr_out;
    logic        int_active;

    interrupt_sequencer #(
        .INT_VECTOR   (VEC),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .int_req      (int_req),
        .rti_req      (rti_req),
        .pc_in        (pc_in),
        .ccr_in       (ccr_in),
        .sp_in        (sp_in),
        .mem_rdata    (mem_rdata),
        .fetch_stall  (fetch_stall),
        .push         (push),
        .pop          (pop),
        .counter_val  (counter_val),
        .stack_addr   (stack_addr),
        .stack_wdata  (stack_wdata),
        .sp_out       (sp_out),
        .sp_we        (sp_we),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .ccr_load     (ccr_load),
        .ccr_out      (ccr_out),
        .int_active   (int_active)
    );

    typedef struct packed {
        logic        push;
        logic        pop;
        logic [1:0]  slot;
        logic [31:0] addr;
        logic [15:0] wdata;
        logic [31:0] spo;
        logic        sp_we;
        logic        pc_load;
        logic [31:0] pca;
        logic        ccr_load;
        logic [2:0]  ccr;
        logic        act;
    } obs_t;

    typedef struct {
        obs_t  e;
        obs_t  m;
        int    cyc;
        string name;
    } sb_t;

    sb_t sbq[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  k;
    logic [15:0] mem [logic [31:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stack memory model behind the memory stage.
    always @(posedge clk) begin
        if (push)
            mem[stack_addr] = stack_wdata;
        if (pop)
            mem_rdata <= mem.exists(stack_addr) ? mem[stack_addr] : 16'h0;
    end

    task automatic chk(string n, logic [127:0] got, logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", n, got, want);
        end
    endtask

    task automatic exp_push(string n, logic [1:0] s, logic [31:0] a,
                            logic [15:0] d, logic [31:0] so);
        sb_t x;
        x.e = '0;
        x.e.push = 1'b1;
        x.e.slot = s;
        x.e.addr = a;
        x.e.wdata = d;
        x.e.spo = so;
        x.e.sp_we = 1'b1;
        x.e.act = 1'b1;
        x.m = '1;
        x.m.pca = '0;
        x.m.ccr = '0;
        x.cyc = -1;
        x.name = n;
        sbq.push_back(x);
    endtask

    task automatic exp_pop(string n, logic [1:0] s, logic [31:0] a);
        sb_t x;
        x.e = '0;
        x.e.pop = 1'b1;
        x.e.slot = s;
        x.e.addr = a;
        x.e.spo = a;
        x.e.sp_we = 1'b1;
        x.m = '1;
        x.m.wdata = '0;
        x.m.pca = '0;
        x.m.ccr = '0;
        x.cyc = -1;
        x.name = n;
        sbq.push_back(x);
    endtask

    task automatic exp_load(string n, logic [31:0] pa, logic [2:0] c,
                            logic a, int at);
        sb_t x;
        x.e = '0;
        x.e.pc_load = 1'b1;
        x.e.pca = pa;
        x.e.ccr_load = 1'b1;
        x.e.ccr = c;
        x.e.act = a;
        x.m = '1;
        x.m.slot = '0;
        x.m.addr = '0;
        x.m.wdata = '0;
        x.m.spo = '0;
        x.cyc = at;
        x.name = n;
        sbq.push_back(x);
    endtask

    task automatic exp_entry(string n, logic [31:0] sp, int at);
        exp_push({n, "_pch"}, 2'd0, sp, 16'h0001, sp - 32'd1);
        exp_push({n, "_pcl"}, 2'd1, sp - 32'd1, 16'h2345, sp - 32'd2);
        exp_push({n, "_ccr"}, 2'd2, sp - 32'd2, 16'h0005, sp - 32'd3);
        exp_load({n, "_vec"}, VEC, 3'b000, 1'b1, at);
    endtask

    // Monitor: every memory-stage request or redirect must match the head.
    always @(negedge clk) begin
        obs_t o;
        sb_t  x;
        if (rst && (push || pop || sp_we || pc_load || ccr_load)) begin
            o = '{push, pop, counter_val, stack_addr, stack_wdata, sp_out,
                  sp_we, pc_load, pc_load_addr, ccr_load, ccr_out,
                  int_active};
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected got %h want none", o);
            end else begin
                x = sbq.pop_front();
                if ((o & x.m) !== x.e) begin
                    errors++;
                    $display("FAIL %s got %h want %h", x.name, o & x.m, x.e);
                end
                if (x.cyc >= 0) begin
                    checks++;
                    if (cyc + 1 != x.cyc) begin
                        errors++;
                        $display("FAIL %s_edge got %0d want %0d",
                                 x.name, cyc + 1 - k, x.cyc - k);
                    end
                end
            end
        end
    end

    task automatic wait_done(string n);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            #2;
            if (sbq.size() == 0 && !fetch_stall)
                return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout got pending %0d want 0", n, sbq.size());
    endtask

    task automatic frame(logic [31:0] sp);
        pc_in  = 32'h0001_2345;
        ccr_in = 3'b101;
        sp_in  = sp;
    endtask

    initial begin
        rst     = 1'b0;
        int_req = 1'b0;
        rti_req = 1'b0;
        pc_in   = '0;
        ccr_in  = '0;
        sp_in   = '0;
        k       = 0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {fetch_stall, push, pop, counter_val, stack_addr,
            stack_wdata, sp_out, sp_we, pc_load, pc_load_addr, ccr_load,
            ccr_out, int_active}, 128'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Interrupt entry.
        frame(32'h0000_0FFF);
        int_req = 1'b1;
        k = cyc + 1;
        exp_entry("int", 32'h0000_0FFF, k + 7);
        @(negedge clk);
        int_req = 1'b0;
        chk("int_stall", {126'd0, fetch_stall, int_active}, 128'b10);
        wait_done("int");

        // RTI restores the frame just pushed.
        sp_in   = 32'h0000_0FFC;
        pc_in   = 32'h0000_0040;
        ccr_in  = 3'b010;
        rti_req = 1'b1;
        k = cyc + 1;
        exp_pop("rti_ccr", 2'd2, 32'h0000_0FFD);
        exp_pop("rti_pcl", 2'd1, 32'h0000_0FFE);
        exp_pop("rti_pch", 2'd0, 32'h0000_0FFF);
        exp_load("rti_res", 32'h0001_2345, 3'b101, 1'b0, k + 7);
        @(negedge clk);
        rti_req = 1'b0;
        chk("rti_stall", {127'd0, fetch_stall}, 128'd1);
        wait_done("rti");

        // Simultaneous: RTI first, then the held interrupt.
        frame(32'h0000_0FFC);
        int_req = 1'b1;
        rti_req = 1'b1;
        k = cyc + 1;
        exp_pop("sim_ccr", 2'd2, 32'h0000_0FFD);
        exp_pop("sim_pcl", 2'd1, 32'h0000_0FFE);
        exp_pop("sim_pch", 2'd0, 32'h0000_0FFF);
        exp_load("sim_res", 32'h0001_2345, 3'b101, 1'b0, k + 7);
        exp_entry("sim", 32'h0000_0FFC, k + 15);
        @(negedge clk);
        int_req = 1'b0;
        rti_req = 1'b0;
        wait_done("sim");

        // Merge: two edges during one service give one more service.
        frame(32'h0000_0FFF);
        int_req = 1'b1;
        k = cyc + 1;
        exp_entry("mrg1", 32'h0000_0FFF, k + 7);
        exp_entry("mrg2", 32'h0000_0FFF, k + 15);
        @(negedge clk);
        int_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (push)
                break;
        end
        int_req = 1'b1;
        @(negedge clk);
        int_req = 1'b0;
        @(negedge clk);
        int_req = 1'b1;
        @(negedge clk);
        int_req = 1'b0;
        wait_done("mrg");
        repeat (20) @(negedge clk);

        // Reset during PUSH_PCL aborts the frame.
        frame(32'h0000_0FFF);
        int_req = 1'b1;
        k = cyc + 1;
        exp_push("rst_pch", 2'd0, 32'h0000_0FFF, 16'h0001, 32'h0000_0FFE);
        exp_push("rst_pcl", 2'd1, 32'h0000_0FFE, 16'h2345, 32'h0000_0FFD);
        @(negedge clk);
        int_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (push && counter_val == 2'd1)
                break;
        end
        #2;
        rst = 1'b0;
        #1;
        chk("reset_abort", {fetch_stall, push, pop, counter_val, stack_addr,
            stack_wdata, sp_out, sp_we, pc_load, pc_load_addr, ccr_load,
            ccr_out, int_active}, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        chk("rst_left", 128'(sbq.size()), 128'd0);

        // SP wrap below zero.
        frame(32'h0000_0000);
        int_req = 1'b1;
        k = cyc + 1;
        exp_push("wrp_pch", 2'd0, 32'h0000_0000, 16'h0001, 32'hFFFF_FFFF);
        exp_push("wrp_pcl", 2'd1, 32'hFFFF_FFFF, 16'h2345, 32'hFFFF_FFFE);
        exp_push("wrp_ccr", 2'd2, 32'hFFFF_FFFE, 16'h0005, 32'hFFFF_FFFD);
        exp_load("wrp_vec", VEC, 3'b000, 1'b1, k + 7);
        @(negedge clk);
        int_req = 1'b0;
        wait_done("wrp");
        repeat (5) @(negedge clk);

        chk("sb_empty", 128'(sbq.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
